// File: rtl/dffrf_wr_arbiter.sv
// dffrf_wr_arbiter: shares the register-file write port between NREQ requesters and sweeps zeros on clear.
// Define DFFRF_WRARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module dffrf_wr_arbiter #(
  parameter int data_w        = 32,
  parameter int addr_w        = 5,
  parameter int NREQ          = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          REQ_VALID,
  input  logic [NREQ*addr_w-1:0]   REQ_ADDR,
  input  logic [NREQ*data_w-1:0]   REQ_DATA,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic                     CLEAR_START,
  output logic                     BUSY,
  output logic                     WE,
  output logic [addr_w-1:0]        RW,
  output logic [data_w-1:0]        DW
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [addr_w:0] CNT_LAST = {1'b0, {addr_w{1'b1}}};
  localparam logic [addr_w:0] CNT_ONE  = {{addr_w{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t ST_RESET = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("dffrf_wr_arbiter: NREQ must be in 2..8");
    end
  endgenerate

  state_t               state_r;
  logic [addr_w:0]      cnt_r;
  logic                 we_r;
  logic [addr_w-1:0]    rw_r;
  logic [data_w-1:0]    dw_r;

  logic                 grant_any_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic [addr_w-1:0]    sel_addr_s;
  logic [data_w-1:0]    sel_data_s;
  logic [NREQ-1:0]      ready_s;
  logic                 xfer_s;

`ifndef DFFRF_WRARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     rr_next_s;
`endif

  // Grant search: first VALID requester starting at the round-robin pointer (or index 0).
  always_comb begin : arb_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DFFRF_WRARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(rr_ptr_r) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
`endif
      cand_idx = cand[IDX_W-1:0];
      if (!grant_any_s && REQ_VALID[cand_idx]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_idx;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Address/data mux for the granted requester.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IDX_W'(i)) begin
        sel_addr_s = REQ_ADDR[i*addr_w +: addr_w];
        sel_data_s = REQ_DATA[i*data_w +: data_w];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_data_s = sel_data_s;
      end
    end
  end

  // One-hot ready, suppressed outside RUN.
  always_comb begin
    ready_s = '0;
    if (state_r == ST_RUN && grant_any_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s    = (state_r == ST_RUN) && grant_any_s;
  assign REQ_READY = ready_s;
  assign BUSY      = (state_r == ST_CLEAR);
  assign WE        = we_r;
  assign RW        = rw_r;
  assign DW        = dw_r;

`ifndef DFFRF_WRARB_FIXED_PRIO_EN
  assign rr_next_s = (grant_idx_s == IDX_W'(NREQ - 1)) ? '0 : (grant_idx_s + IDX_W'(1));

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_r <= '0;
    end else if (xfer_s) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // RUN/CLEAR sequencer driving the registered write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_RESET;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      rw_r    <= '0;
      dw_r    <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (xfer_s) begin
            we_r <= 1'b1;
            rw_r <= sel_addr_s;
            dw_r <= sel_data_s;
          end else begin
            we_r <= 1'b0;
          end
          // A concurrent transfer above still completes before the sweep starts.
          if (CLEAR_START) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_CLEAR: begin
          we_r  <= 1'b1;
          rw_r  <= cnt_r[addr_w-1:0];
          dw_r  <= '0;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        default: begin
          state_r <= ST_RESET;
          cnt_r   <= '0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dffrf_wr_arbiter.sv
// Scoreboard bench for dffrf_wr_arbiter: a cycle-level reference model queues the expected write port
// values; a monitor pops one entry per cycle and a shadow register file is compared at the end.
module tb_dffrf_wr_arbiter;
  localparam int DWW   = 32;
  localparam int AW    = 5;
  localparam int NREQ  = 2;
  localparam int DEPTH = 32;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*AW-1:0]   REQ_ADDR;
  logic [NREQ*DWW-1:0]  REQ_DATA;
  logic [NREQ-1:0]      REQ_READY;
  logic                 CLEAR_START;
  logic                 BUSY;
  logic                 WE;
  logic [AW-1:0]        RW;
  logic [DWW-1:0]       DW;

  always #5 CLK = ~CLK;

  dffrf_wr_arbiter #(.data_w(DWW), .addr_w(AW), .NREQ(NREQ), .INIT_ON_RESET(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .CLEAR_START(CLEAR_START), .BUSY(BUSY), .WE(WE), .RW(RW), .DW(DW)
  );

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  a;
    logic [DWW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit in_reset = 1'b1;

  int             m_ptr, m_busy_left, m_cnt;
  logic [AW-1:0]  m_last_a;
  logic [DWW-1:0] m_last_d;
  logic [DWW-1:0] model_mem [DEPTH];
  logic [DWW-1:0] rf [DEPTH];
  bit             pend_we = 1'b0;
  logic [AW-1:0]  pend_a;
  logic [DWW-1:0] pend_d;

  logic [NREQ-1:0] s_valid;
  logic [AW-1:0]   s_addr [NREQ];
  logic [DWW-1:0]  s_data [NREQ];
  int              last_grant = -1;

  always @(posedge CLK) if (WE) rf[RW] <= DW;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_busy_left = DEPTH;
    m_cnt = 0;
    m_last_a = '0;
    m_last_d = '0;
    last_grant = -1;
  endtask

  // One clock cycle: drive inputs at posedge+2, check ready/busy, predict the write, then advance.
  task automatic do_cycle(input bit clr);
    int grant;
    int c;
    bit run_now;
    logic [NREQ-1:0] exp_ready;
    exp_t e;
    REQ_VALID = s_valid;
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADDR[i*AW +: AW]   = s_addr[i];
      REQ_DATA[i*DWW +: DWW] = s_data[i];
    end
    CLEAR_START = clr;
    #1;
    run_now = (m_busy_left == 0);
    grant = -1;
    exp_ready = '0;
    if (run_now) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef DFFRF_WRARB_FIXED_PRIO_EN
        c = k;
`else
        c = (m_ptr + k) % NREQ;
`endif
        if (grant < 0 && s_valid[c]) grant = c;
      end
    end
    if (grant >= 0) exp_ready[grant] = 1'b1;
    check("ready", REQ_READY, exp_ready);
    check("busy", BUSY, !run_now);
    if (!run_now) begin
      e = '{we: 1'b1, a: m_cnt[AW-1:0], d: '0};
      m_cnt++;
      m_busy_left--;
    end else if (grant >= 0) begin
      e = '{we: 1'b1, a: s_addr[grant], d: s_data[grant]};
      m_ptr = (grant + 1) % NREQ;
    end else begin
      e = '{we: 1'b0, a: m_last_a, d: m_last_d};
    end
    if (run_now && clr) begin
      m_busy_left = DEPTH;
      m_cnt = 0;
    end
    m_last_a = e.a;
    m_last_d = e.d;
    exp_q.push_back(e);
    last_grant = grant;
    @(posedge CLK);
    #2;
  endtask

  // Requesters hold address/data until granted; occasionally withdraw.
  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (s_valid[i] && last_grant != i) begin
        if ($urandom_range(0, 15) == 0) s_valid[i] = 1'b0;
      end else begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_addr[i]  = AW'($urandom_range(0, DEPTH - 1));
        s_data[i]  = $urandom;
      end
    end
  endtask

  task automatic do_reset_pulse();
    RST_N = 1'b0;
    in_reset = 1'b1;
    #1;
    check("rst_we", WE, 1'b0);
    check("rst_rw", RW, '0);
    check("rst_dw", DW, '0);
    check("rst_busy", BUSY, 1'b1);
    check("rst_ready", REQ_READY, '0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: commit the previous cycle's expected write to the model memory, then compare this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (pend_we && RST_N) model_mem[pend_a] = pend_d;
      pend_we = 1'b0;
      #1;
      if (!in_reset) begin
        if (exp_q.size() == 0) begin
          check("we_unexpected", WE, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("we", WE, e.we);
          check("rw", RW, e.a);
          check("dw", DW, e.d);
          pend_we = e.we;
          pend_a  = e.a;
          pend_d  = e.d;
        end
      end
    end
  end

  initial begin
    REQ_VALID = '0;
    REQ_ADDR = '0;
    REQ_DATA = '0;
    CLEAR_START = 1'b0;
    s_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_addr[i] = '0;
      s_data[i] = '0;
    end
    RST_N = 1'b0;
    in_reset = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    check("por_we", WE, 1'b0);
    check("por_rw", RW, '0);
    check("por_dw", DW, '0);
    check("por_busy", BUSY, 1'b1);
    check("por_ready", REQ_READY, '0);
    RST_N = 1'b1;
    in_reset = 1'b0;

    repeat (36) do_cycle(1'b0);

    s_valid = 2'b11;
    s_addr[0] = 5'd3; s_data[0] = 32'h0000_00A0;
    s_addr[1] = 5'd4; s_data[1] = 32'h0000_00B1;
    repeat (4) do_cycle(1'b0);
    s_valid = '0;
    repeat (2) do_cycle(1'b0);

    s_valid = 2'b10;
    s_addr[1] = 5'd7; s_data[1] = 32'hDEAD_BEEF;
    do_cycle(1'b0);
    s_valid = '0;
    repeat (2) do_cycle(1'b0);

    s_valid = 2'b01;
    s_addr[0] = 5'd5; s_data[0] = 32'h0000_0055;
    do_cycle(1'b1);
    s_valid = '0;
    repeat (5) do_cycle(1'b0);
    do_cycle(1'b1);
    repeat (30) do_cycle(1'b0);

    repeat (400) begin
      rand_reqs();
      do_cycle($urandom_range(0, 63) == 0);
    end

    s_valid = '0;
    repeat (40) do_cycle(1'b0);
    do_cycle(1'b1);
    repeat (10) do_cycle(1'b0);
    do_reset_pulse();
    repeat (20) begin
      rand_reqs();
      do_cycle(1'b0);
    end
    repeat (100) begin
      rand_reqs();
      do_cycle(1'b0);
    end
    s_valid = '0;
    repeat (45) do_cycle(1'b0);
    repeat (3) @(posedge CLK);
    #2;
    for (int i = 0; i < DEPTH; i++) check("rf_word", rf[i], model_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
